// File: rtl/spi_flash_reader.sv
// SPI mode-0 flash reader: wakes the flash with 0xAB, then serves
// 32-bit little-endian reads (0x03 + 24-bit address) over valid/ready.
module spi_flash_reader #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = $clog2(2 * CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    WAKE,
    WAKE_GAP,
    IDLE,
    XFER,
    GAP
  } state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [GW-1:0] gap_cnt;
  logic [5:0]    bit_cnt;
  logic [30:0]   tx_sr;
  logic [31:0]   rx_sr;

  logic sck_tick;
  logic last_bit;

  assign sck_tick = (div_cnt == DIV_MAX);
  assign last_bit = (state == WAKE) ? (bit_cnt == 6'd7)
                                    : (bit_cnt == 6'd63);

  // Single FSM: SCK divider, shift engine, gaps and handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= WAKE;
      div_cnt   <= '0;
      gap_cnt   <= '0;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      flash_csb <= 1'b1;
      flash_clk <= 1'b0;
      flash_io0 <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        WAKE, XFER: begin
          if (state == WAKE && flash_csb) begin
            flash_csb <= 1'b0;
            busy      <= 1'b1;
            flash_io0 <= 1'b1;
            tx_sr     <= {7'h2b, 24'h0};
            div_cnt   <= '0;
            bit_cnt   <= '0;
          end else if (!sck_tick) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!flash_clk) begin
              flash_clk <= 1'b1;
              rx_sr     <= {rx_sr[30:0], flash_io1};
            end else if (last_bit) begin
              flash_clk <= 1'b0;
              flash_csb <= 1'b1;
              flash_io0 <= 1'b0;
              gap_cnt   <= '0;
              if (state == XFER) begin
                rsp_valid <= 1'b1;
                rsp_data  <= {rx_sr[7:0], rx_sr[15:8],
                              rx_sr[23:16], rx_sr[31:24]};
                state     <= GAP;
              end else begin
                state <= WAKE_GAP;
              end
            end else begin
              flash_clk <= 1'b0;
              flash_io0 <= tx_sr[30];
              tx_sr     <= {tx_sr[29:0], 1'b0};
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end
        end
        WAKE_GAP, GAP: begin
          if (gap_cnt == GAP_MAX) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (req_valid && req_ready) begin
            state     <= XFER;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            flash_csb <= 1'b0;
            flash_io0 <= 1'b0;
            tx_sr     <= {7'h03, req_addr};
            div_cnt   <= '0;
            bit_cnt   <= '0;
          end
        end
        default: state <= WAKE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Randomised bench for spi_flash_reader with a behavioural flash model.
// Two builds run side by side: CLK_DIV=2 (index 0) and CLK_DIV=1 (index 1).
module tb_spi_flash_reader;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  logic        req_valid [2] = '{1'b0, 1'b0};
  logic [23:0] req_addr  [2] = '{24'h0, 24'h0};
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_data  [2];
  logic        busy      [2];
  logic        f_csb     [2];
  logic        f_clk     [2];
  logic        f_io0     [2];
  logic        f_io1     [2] = '{1'b0, 1'b0};

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int          nbit      [2] = '{0, 0};
  logic [31:0] cmd       [2] = '{32'h0, 32'h0};
  int          frames    [2] = '{0, 0};
  int          frame_n   [2] = '{0, 0};
  logic [31:0] frame_cmd [2] = '{32'h0, 32'h0};
  int          rsp_cnt   [2] = '{0, 0};
  int          glitch    [2] = '{0, 0};

  logic [7:0] mem [logic [23:0]];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] byte_at(input logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'h5a;
  endfunction

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    logic [23:0] a1, a2, a3;
    a1 = a + 24'd1;
    a2 = a + 24'd2;
    a3 = a + 24'd3;
    return {byte_at(a3), byte_at(a2), byte_at(a1), byte_at(a)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    spi_flash_reader #(.CLK_DIV(2 - g)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_addr  (req_addr[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_data  (rsp_data[g]),
      .busy      (busy[g]),
      .flash_csb (f_csb[g]),
      .flash_clk (f_clk[g]),
      .flash_io0 (f_io0[g]),
      .flash_io1 (f_io1[g])
    );

    // Flash side: collect MOSI on SCK rise, log a frame at csb rise.
    always @(posedge f_clk[g] or posedge f_csb[g]) begin
      if (f_csb[g] === 1'b1) begin
        frame_n[g]   = nbit[g];
        frame_cmd[g] = cmd[g];
        frames[g]    = frames[g] + 1;
        nbit[g]      = 0;
      end else begin
        if (nbit[g] < 32) cmd[g] = {cmd[g][30:0], f_io0[g]};
        nbit[g] = nbit[g] + 1;
      end
    end

    // Flash side: present read data on SCK fall after the header.
    always @(negedge f_clk[g]) begin : drv
      int j;
      logic [7:0] b;
      if (nbit[g] >= 32) begin
        j = nbit[g] - 32;
        b = byte_at(cmd[g][23:0] + 24'(j / 8));
        f_io1[g] = b[7 - (j % 8)];
      end
    end

    always @(negedge clk) begin
      if (rsp_valid[g] === 1'b1) rsp_cnt[g] = rsp_cnt[g] + 1;
      if (f_csb[g] === 1'b1 && f_clk[g] === 1'b1)
        glitch[g] = glitch[g] + 1;
    end
  end

  task automatic wait_ready(input int i, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (req_ready[i] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input int i, input bit noise,
                          output int t, output bit ok);
    ok = 1'b0;
    t = 0;
    for (int n = 0; n < 3000; n++) begin
      if (rsp_valid[i] === 1'b1) begin
        ok = 1'b1;
        t = cyc;
        break;
      end
      if (noise) begin
        req_valid[i] = 1'($urandom);
        req_addr[i]  = 24'($urandom);
      end
      @(negedge clk);
    end
    req_valid[i] = 1'b0;
    if (!ok) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_read(input int i, input logic [23:0] a,
                         input bit noise, input int lat,
                         input string tag);
    int t0, t1, c0, f0;
    bit ok;
    wait_ready(i, ok);
    if (!ok) return;
    req_addr[i]  = a;
    req_valid[i] = 1'b1;
    t0 = cyc;
    c0 = rsp_cnt[i];
    f0 = frames[i];
    @(negedge clk);
    req_valid[i] = 1'b0;
    wait_rsp(i, noise, t1, ok);
    if (!ok) return;
    chk({tag, "_lat"}, 32'(t1 - t0), 32'(lat));
    chk({tag, "_data"}, rsp_data[i], exp_word(a));
    repeat (3) @(negedge clk);
    chk({tag, "_hold"}, rsp_data[i], exp_word(a));
    chk({tag, "_pulses"}, 32'(rsp_cnt[i] - c0), 32'd1);
    chk({tag, "_frames"}, 32'(frames[i] - f0), 32'd1);
    chk({tag, "_mosi"}, frame_cmd[i], {8'h03, a});
    chk({tag, "_nbits"}, 32'(frame_n[i]), 32'd64);
  endtask

  task automatic wake_check(input string tag);
    int phase, te, tr;
    phase = 0;
    te = 0;
    tr = 0;
    for (int n = 0; n < 500; n++) begin
      case (phase)
        0: if (f_csb[0] === 1'b0) phase = 1;
        1: if (f_csb[0] === 1'b1) begin
             te = cyc;
             phase = 2;
           end
        2: if (req_ready[0] === 1'b1) begin
             tr = cyc;
             phase = 3;
           end
        default: ;
      endcase
      if (phase == 3) break;
      @(negedge clk);
    end
    chk({tag, "_done"}, 32'(phase), 32'd3);
    chk({tag, "_gap"}, 32'(tr - te), 32'd4);
    chk({tag, "_nbits"}, 32'(frame_n[0]), 32'd8);
    chk({tag, "_byte"}, {24'h0, frame_cmd[0][7:0]}, 32'hab);
  endtask

  initial begin : main
    int t0, t1, t2, c0;
    bit ok;
    logic [23:0] a;

    mem[24'h100000] = 8'h11;
    mem[24'h100001] = 8'h22;
    mem[24'h100002] = 8'h33;
    mem[24'h100003] = 8'h44;

    repeat (3) @(negedge clk);
    chk("rst_csb", {31'h0, f_csb[0]}, 32'd1);
    chk("rst_sck", {31'h0, f_clk[0]}, 32'd0);
    chk("rst_io0", {31'h0, f_io0[0]}, 32'd0);
    chk("rst_ready", {31'h0, req_ready[0]}, 32'd0);
    chk("rst_rspv", {31'h0, rsp_valid[0]}, 32'd0);
    chk("rst_data", rsp_data[0], 32'd0);
    chk("rst_busy", {31'h0, busy[0]}, 32'd0);

    resetn = 1'b1;
    wake_check("wake");

    do_read(0, 24'h100000, 1'b0, 257, "rd0");

    // Back-to-back with req_valid held high.
    wait_ready(0, ok);
    if (ok) begin
      req_addr[0]  = 24'h100004;
      req_valid[0] = 1'b1;
      @(negedge clk);
      req_addr[0] = 24'h100008;
      for (int n = 0; n < 3000; n++) begin
        if (rsp_valid[0] === 1'b1) break;
        @(negedge clk);
      end
      t1 = cyc;
      chk("b2b_data0", rsp_data[0], exp_word(24'h100004));
      @(negedge clk);
      t2 = 0;
      for (int n = 0; n < 100; n++) begin
        if (req_ready[0] === 1'b1) begin
          t2 = cyc;
          break;
        end
        @(negedge clk);
      end
      chk("b2b_spacing", 32'(t2 - t1), 32'd4);
      @(negedge clk);
      req_valid[0] = 1'b0;
      wait_rsp(0, 1'b0, t0, ok);
      if (ok) begin
        chk("b2b_data1", rsp_data[0], exp_word(24'h100008));
        chk("b2b_lat1", 32'(t0 - t2), 32'd257);
      end
    end

    do_read(0, 24'h100010, 1'b1, 257, "noise");

    for (int k = 0; k < 5; k++) begin
      a = (k == 0) ? 24'hfffffe : 24'($urandom);
      repeat ($urandom_range(0, 7)) @(negedge clk);
      do_read(0, a, 1'($urandom_range(0, 1)), 257, "rnd");
    end

    // Reset in the middle of the data phase.
    wait_ready(0, ok);
    req_addr[0]  = 24'h100000;
    req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    c0 = rsp_cnt[0];
    for (int n = 0; n < 2000; n++) begin
      if (nbit[0] >= 40) break;
      @(negedge clk);
    end
    chk("mr_bit40", {31'h0, nbit[0] >= 40}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("mr_csb", {31'h0, f_csb[0]}, 32'd1);
    chk("mr_sck", {31'h0, f_clk[0]}, 32'd0);
    chk("mr_rspv", {31'h0, rsp_valid[0]}, 32'd0);
    chk("mr_data", rsp_data[0], 32'd0);
    chk("mr_busy", {31'h0, busy[0]}, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    wake_check("wake2");
    chk("mr_no_rsp", 32'(rsp_cnt[0] - c0), 32'd0);
    do_read(0, 24'h100000, 1'b0, 257, "rd_rst");

    do_read(1, 24'h100000, 1'b0, 129, "div1");
    do_read(1, 24'($urandom), 1'b0, 129, "div1_rnd");

    chk("glitch0", 32'(glitch[0]), 32'd0);
    chk("glitch1", 32'(glitch[1]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
Synthesizable single-lane SPI flash master (SPI mode 0) that fetches 32-bit words from an external serial flash for the SoC fabric.
- After reset it issues a release-from-power-down command (0xAB).
- Each accepted request then runs one read transaction: command 0x03, a 24-bit address, and 4 data bytes.
- It sits between the fabric-side valid/ready request port and the flash pins. It is the initiator matching the testbench flash model.

Parameters:
CLK_DIV, 2, clk cycles per SCK half-period; legal range is 1 and above.

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
req_valid  input  1  read request valid
req_ready  output  1  block idle and able to accept a request
req_addr  input  24  byte address, captured on acceptance
rsp_valid  output  1  one-cycle pulse: rsp_data holds a new word
rsp_data  output  32  read word, little-endian (byte at req_addr is in [7:0])
busy  output  1  high from reset release until IDLE, and during transactions
flash_csb  output  1  chip select, active low
flash_clk  output  1  SCK, idle low
flash_io0  output  1  MOSI
flash_io1  input  1  MISO

Behaviour:
- Reset (resetn low, asynchronous):
  - flash_csb=1; flash_clk=0; flash_io0=0.
  - req_ready=0; rsp_valid=0; rsp_data=0; busy=0.
  - All counters and state are cleared.
  - Reset mid-transaction aborts it immediately. No rsp_valid is produced.
- States: WAKE, WAKE_GAP, IDLE, XFER, GAP.
- Release from reset → WAKE; busy=1.
  - Shift out 0xAB, 8 bits MSB first, then raise csb.
  - WAKE_GAP: csb held high for 2*CLK_DIV cycles, then → IDLE.
- IDLE: req_ready=1 and busy=0.
  - Acceptance is req_valid && req_ready in cycle T.
  - req_addr is latched. The next state is XFER and req_ready falls at T+1.
- XFER:
  - flash_csb falls at T+1.
  - 64 SCK periods: 32 bits out ({0x03, addr[23:0]}, MSB first), then 32 bits in.
- Bit timing:
  - flash_io0 is updated only while flash_clk is low: at csb fall, and on each SCK falling edge.
  - SCK rising edges fall at T+1+(2k+1)*CLK_DIV and falling edges at T+1+(2k+2)*CLK_DIV, for k=0..63.
  - flash_io1 is sampled on SCK rising edges for k=32..63.
  - Each received byte is assembled MSB first. Bytes 0..3 go to rsp_data[7:0], [15:8], [23:16], [31:24].
  - flash_io0 is driven 0 during the data phase.
- End of transaction, at the 64th falling edge (cycle T+1+128*CLK_DIV):
  - csb=1 and rsp_valid=1 for exactly one cycle, with rsp_data updated in the same cycle.
  - rsp_data then holds until the next response.
  - Latency from acceptance to rsp_valid = 1+128*CLK_DIV cycles (257 at default).
- GAP: csb stays high for 2*CLK_DIV cycles, then → IDLE. Minimum request-to-request spacing is 1+130*CLK_DIV cycles.
- Ignored inputs:
  - req_valid outside IDLE is ignored; there is no queueing.
  - req_addr changes after acceptance have no effect.
- Address wrap is flash-side: 0xFFFFFE returns bytes at FFFFFE, FFFFFF, 000000, 000001. The block does no address arithmetic.
- flash_clk must never glitch, and must never be high while csb is high.

Test Plan:
- Reset release, CLK_DIV=2:
  - csb falls at the first WAKE cycle; io0 sampled on the 8 SCK rising edges = 1,0,1,0,1,0,1,1 (0xAB); csb high afterwards.
  - req_ready rises 4 cycles after csb rises.
- Flash model preloaded with 0x100000..0x100003 = 11 22 33 44; request addr 0x100000:
  - MOSI stream = 03 10 00 00.
  - rsp_data=0x44332211 with a single rsp_valid pulse exactly 257 cycles after acceptance.
- Back-to-back requests 0x100004 then 0x100008, req_valid held high:
  - Second acceptance occurs exactly 4 cycles after the first rsp_valid.
  - Responses are correct words; csb is high ≥4 cycles between transactions.
- req_valid toggling and req_addr changing during XFER:
  - No extra acceptance; the transaction uses the latched address; exactly one rsp_valid.
- resetn asserted at bit 40 of a read:
  - Immediately csb=1, flash_clk=0, rsp_valid=0, rsp_data=0.
  - After release, the wake 0xAB sequence repeats, then a fresh read returns correct data.
- CLK_DIV=1 build, read at 0x100000:
  - SCK period 2 cycles; latency 129 cycles; rsp_data=0x44332211.
